// File: rtl/matrix_pkg.sv
// Shared types and sizing for the matrix deserializer and its element_add consumer.
// Matrices are packed row-major: element [r][c].
package matrix_pkg;

  localparam int DIM      = 8;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(DIM * DIM);
  localparam int LAST_IDX = DIM * DIM - 1;

  typedef logic [0:DIM-1][0:DIM-1][DATA_W-1:0] matrix_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL
  } bank_state_t;

  function automatic logic [IDX_W-1:0] flat_idx(input int r, input int c);
    return IDX_W'(r * DIM + c);
  endfunction

endpackage

// File: rtl/matrix_deserializer_if.sv
// Element stream in, whole-matrix bus out, plus the sticky framing flag.
// The slave modport is the deserializer; master is the producer/consumer side.
interface matrix_deserializer_if;
  import matrix_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  matrix_t           out_matrix;
  logic              err_frame;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_matrix, err_frame
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_matrix, err_frame
  );

endinterface

// File: rtl/matrix_bank.sv
// One DIM x DIM storage bank with its own fill/hold state.
// state   | meaning
// EMPTY   | no valid contents, ready for the first element
// FILLING | some elements written, waiting for the last index
// FULL    | complete matrix held until the consumer takes it
module matrix_bank
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              wlast,
  input  logic              rd,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output bank_state_t       state,
  output matrix_t           data
);

  bank_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (we) state_nxt = wlast ? FULL : FILLING;
      FILLING: if (we && wlast) state_nxt = FULL;
      FULL:    if (rd) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (we) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (idx == flat_idx(r, c)) data[r][c] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_deserializer.sv
// Assembles a row-major element stream into whole matrices using two ping-pong banks,
// so one matrix can fill while the previous one is held for the consumer.
module matrix_deserializer
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_deserializer_if.slave bus
);

  logic             wr_sel;
  logic             rd_sel;
  logic             ready_en;
  logic             err_frame_q;
  logic [IDX_W-1:0] idx;

  bank_state_t bank_st [2];
  matrix_t     bank_q  [2];

  logic       accept;
  logic       idx_last;
  logic       out_valid;
  logic       in_ready;
  logic       rd_fire;
  logic [1:0] we;
  logic [1:0] rd;

  assign idx_last  = (idx == IDX_W'(LAST_IDX));
  // ready_en keeps in_ready low until the first edge after reset release
  assign in_ready  = ready_en && (bank_st[wr_sel] != FULL);
  assign out_valid = (bank_st[rd_sel] == FULL);
  assign accept    = bus.in_valid && in_ready;
  assign rd_fire   = out_valid && bus.out_ready;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_matrix = bank_q[rd_sel];
  assign bus.err_frame  = err_frame_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign we[b] = accept  && (wr_sel == 1'(b));
    assign rd[b] = rd_fire && (rd_sel == 1'(b));

    matrix_bank u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[b]),
      .wlast (idx_last),
      .rd    (rd[b]),
      .idx   (idx),
      .wdata (bus.in_data),
      .state (bank_st[b]),
      .data  (bank_q[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en    <= 1'b0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      idx         <= '0;
      err_frame_q <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        idx <= idx_last ? '0 : idx + IDX_W'(1);
        if (idx_last) wr_sel <= ~wr_sel;
        // framing always follows idx; a disagreeing in_last only raises the flag
        if (bus.in_last != idx_last) err_frame_q <= 1'b1;
      end
      if (rd_fire) rd_sel <= ~rd_sel;
    end
  end

endmodule

// File: tb/tb_matrix_deserializer.sv
// Bench for matrix_deserializer: a scoreboard of matrices built from accepted beats,
// compared element by element on every output handshake.
module tb_matrix_deserializer;
  import matrix_pkg::*;

  logic clk;
  logic rst_n;

  matrix_deserializer_if bus ();

  matrix_deserializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int cyc = 0;
  int hs_count = 0;
  int model_idx = 0;
  int hs_cyc[$];
  matrix_t sb[$];
  matrix_t model_mat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int m, input int i);
    return 32'hA000_0000 + 32'(m) * 32'h0001_0000 + 32'(i) * 32'd3;
  endfunction

  // Scoreboard: accepted beats build the expected matrix; handshakes pop and compare.
  always @(negedge clk) begin
    matrix_t exp_m;
    #2;
    cyc++;
    if (!rst_n) begin
      model_idx = 0;
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        model_mat[model_idx / DIM][model_idx % DIM] = bus.in_data;
        if (model_idx == LAST_IDX) begin
          sb.push_back(model_mat);
          model_idx = 0;
        end else begin
          model_idx++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("sb_empty_on_output", 32'd1, 32'd0);
        end else begin
          exp_m = sb.pop_front();
          for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
              chk($sformatf("out[%0d][%0d]", r, c), bus.out_matrix[r][c], exp_m[r][c]);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic last);
    bit acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int k = 0; k < 600 && !acc; k++) begin
      #2;
      acc = bus.in_ready;
      @(negedge clk);
      if (!acc) stalls++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_matrix(input int m);
    for (int i = 0; i < DIM * DIM; i++) send_beat(pat(m, i), i == LAST_IDX);
  endtask

  task automatic wait_hs(input int target, input string tag);
    for (int k = 0; k < 800 && hs_count < target; k++) begin
      @(negedge clk);
      #3;
    end
    chk(tag, 32'(hs_count >= target), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    bit sender_done;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_matrix_zero", 32'(|bus.out_matrix), 32'd0);
    chk("rst_err_frame", 32'(bus.err_frame), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // Single matrix, data = r*8+c+1, latency and one-cycle out_valid
    bus.out_ready = 1'b1;
    for (int i = 0; i < DIM * DIM; i++) begin
      send_beat(32'(i + 1), i == LAST_IDX);
      if (i == LAST_IDX - 1) chk("single_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("single_valid_next_cycle", 32'(bus.out_valid), 32'd1);
    chk("single_m01", bus.out_matrix[0][1], 32'd2);
    chk("single_m10", bus.out_matrix[1][0], 32'd9);
    chk("single_m11", bus.out_matrix[1][1], 32'd10);
    chk("single_m77", bus.out_matrix[7][7], 32'd64);
    @(negedge clk);
    chk("single_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("single_hs_count", 32'(hs_count), 32'd1);

    // Backpressure: three matrices with the consumer stalled
    bus.out_ready = 1'b0;
    base = hs_count;
    sender_done = 1'b0;
    fork
      begin
        for (int m = 0; m < 3; m++) send_matrix(m);
        sender_done = 1'b1;
      end
    join_none
    repeat (150) @(negedge clk);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_hold_00", bus.out_matrix[0][0], pat(0, 0));
    chk("bp_hold_77", bus.out_matrix[7][7], pat(0, LAST_IDX));
    repeat (20) @(negedge clk);
    chk("bp_still_low", 32'(bus.in_ready), 32'd0);
    chk("bp_stable_35", bus.out_matrix[3][5], pat(0, 3 * DIM + 5));
    chk("bp_no_output", 32'(hs_count), 32'(base));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 800 && !sender_done; k++) @(negedge clk);
    chk("bp_sender_done", 32'(sender_done), 32'd1);
    wait_hs(base + 3, "bp_drain");

    // Full throughput: four matrices, no stalls, outputs every 64 cycles
    stalls = 0;
    hs_cyc.delete();
    base = hs_count;
    for (int m = 20; m < 24; m++) send_matrix(m);
    wait_hs(base + 4, "tp_drain");
    chk("tp_no_stalls", 32'(stalls), 32'd0);
    chk("tp_hs_n", 32'(hs_cyc.size()), 32'd4);
    for (int k = 1; k < hs_cyc.size(); k++)
      chk($sformatf("tp_gap%0d", k), 32'(hs_cyc[k] - hs_cyc[k-1]), 32'd64);

    // Framing error: in_last on beat 10
    base = hs_count;
    for (int i = 0; i < DIM * DIM; i++) begin
      send_beat(pat(5, i), i == 10);
      if (i == 9)  chk("frame_before", 32'(bus.err_frame), 32'd0);
      if (i == 10) chk("frame_set", 32'(bus.err_frame), 32'd1);
      if (i == 11) chk("frame_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    chk("frame_completes", 32'(bus.out_valid), 32'd1);
    wait_hs(base + 1, "frame_drain");
    chk("frame_sticky", 32'(bus.err_frame), 32'd0 + 32'd1);

    // Reset while one matrix is held and another is part-filled
    bus.out_ready = 1'b0;
    send_matrix(10);
    for (int i = 0; i <= 30; i++) send_beat(pat(11, i), 1'b0);
    chk("mid_held_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_err_frame", 32'(bus.err_frame), 32'd0);
    chk("mid_rst_matrix_zero", 32'(|bus.out_matrix), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = hs_count;
    bus.out_ready = 1'b1;
    send_matrix(12);
    wait_hs(base + 1, "mid_fresh_drain");
    chk("mid_one_output", 32'(hs_count), 32'(base + 1));
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
